// File: rtl/sqgendemo.sv
// Square-wave tone generator: four synchronized note buttons, an octave selector and a
// volume selector produce an 8-bit unsigned sample stream, one registered sample per clock.
module sqgendemo #(
    parameter int CLK_HZ = 50_000_000,
    parameter int HP_A   = 454545,
    parameter int HP_C   = 382227,
    parameter int HP_E   = 303379,
    parameter int HP_G   = 255102
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       butt_1,
    input  logic       butt_2,
    input  logic       butt_3,
    input  logic       butt_4,
    input  logic [5:0] oct,
    input  logic [1:0] volsel,
    output logic [7:0] audio_out
);

    localparam int HP_W = 19;

    typedef enum logic [2:0] {
        NOTE_NONE,
        NOTE_A,
        NOTE_C,
        NOTE_E,
        NOTE_G
    } note_t;

    if (CLK_HZ <= 0) begin : g_clk_hz_invalid
        $error("sqgendemo: CLK_HZ must be positive");
    end

    logic [3:0]      butt_s1;
    logic [3:0]      butt_s2;
    logic [HP_W-1:0] cnt;
    logic            phase;
    note_t           last_note;
    logic [2:0]      last_k;

    note_t           note_sel;
    logic [2:0]      k;
    logic [HP_W-1:0] hp;
    logic [HP_W-1:0] n_half;
    logic [7:0]      amp;

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        note_sel = NOTE_NONE;
        if      (butt_s2[0]) note_sel = NOTE_A;
        else if (butt_s2[1]) note_sel = NOTE_C;
        else if (butt_s2[2]) note_sel = NOTE_E;
        else if (butt_s2[3]) note_sel = NOTE_G;

        k = 3'd0;
        for (int i = 0; i < 6; i++) begin
            if (oct[i]) k = 3'(i + 1);
        end

        case (note_sel)
            NOTE_A:  hp = HP_W'(HP_A);
            NOTE_C:  hp = HP_W'(HP_C);
            NOTE_E:  hp = HP_W'(HP_E);
            NOTE_G:  hp = HP_W'(HP_G);
            default: hp = '0;
        endcase
        n_half = hp >> k;

        case (volsel)
            2'b00:   amp = 8'h20;
            2'b01:   amp = 8'h40;
            2'b10:   amp = 8'h80;
            default: amp = 8'hFF;
        endcase
    end

    // The sample is taken from the phase being written this cycle, so a level starting on a
    // restart or a toggle edge lasts exactly n_half samples.
    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            butt_s1   <= '0;
            butt_s2   <= '0;
            cnt       <= '0;
            phase     <= 1'b1;
            last_note <= NOTE_NONE;
            last_k    <= 3'd0;
            audio_out <= 8'h00;
        end else begin
            butt_s1   <= {butt_4, butt_3, butt_2, butt_1};
            butt_s2   <= butt_s1;
            last_note <= note_sel;
            last_k    <= k;
            if (note_sel == NOTE_NONE) begin
                cnt       <= '0;
                phase     <= 1'b1;
                audio_out <= 8'h00;
            end else if (note_sel != last_note || k != last_k) begin
                cnt       <= '0;
                audio_out <= phase ? amp : 8'h00;
            end else if (cnt == n_half - HP_W'(1)) begin
                cnt       <= '0;
                phase     <= ~phase;
                audio_out <= phase ? 8'h00 : amp;
            end else begin
                cnt       <= cnt + HP_W'(1);
                audio_out <= phase ? amp : 8'h00;
            end
        end
    end

endmodule

// File: tb/tb_sqgendemo.sv
// Bench for sqgendemo: the stimulus pushes expected (level, run length) pairs; a monitor
// measures each completed constant-level run of audio_out and compares it with the queue head.
module tb_sqgendemo;

    // Shortened half-periods: A>>6 = 7, C>>6 = 5, A>>3 = 56.
    localparam int HP_A = 455;
    localparam int HP_C = 382;
    localparam int HP_E = 303;
    localparam int HP_G = 255;

    typedef struct {
        logic [7:0] lvl;
        int         len;
    } run_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       butt_1, butt_2, butt_3, butt_4;
    logic [5:0] oct;
    logic [1:0] volsel;
    logic [7:0] audio_out;

    int   checks = 0;
    int   errors = 0;
    int   edge_no = 0;
    int   run_idx = 0;
    run_t exp_q[$];

    sqgendemo #(
        .CLK_HZ(50_000_000),
        .HP_A  (HP_A),
        .HP_C  (HP_C),
        .HP_E  (HP_E),
        .HP_G  (HP_G)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .butt_1   (butt_1),
        .butt_2   (butt_2),
        .butt_3   (butt_3),
        .butt_4   (butt_4),
        .oct      (oct),
        .volsel   (volsel),
        .audio_out(audio_out)
    );

    always #5 clk = ~clk;

    task automatic push(input logic [7:0] lvl, input int len);
        run_t r;
        r.lvl = lvl;
        r.len = len;
        exp_q.push_back(r);
    endtask

    // Edges are numbered from the first edge after reset release; inputs assigned after
    // this call are seen at edge e.
    task automatic seen_at(input int e);
        repeat (e - 1 - edge_no) @(posedge clk);
        #1;
        edge_no = e - 1;
    endtask

    task automatic check(input string name, input logic [7:0] lvl, input int len, input run_t exp_r);
        checks++;
        if (lvl !== exp_r.lvl || len != exp_r.len) begin
            errors++;
            $display("FAIL %s: got level 0x%02h for %0d clocks, expected 0x%02h for %0d clocks",
                     name, lvl, len, exp_r.lvl, exp_r.len);
        end
    endtask

    // Monitor: one comparison per completed run of a constant output level.
    initial begin
        logic [7:0] cur_lvl;
        int         run_len;
        run_t       e;
        @(negedge clk);
        cur_lvl = audio_out;
        run_len = 1;
        forever begin
            @(negedge clk);
            if (audio_out === cur_lvl) begin
                run_len++;
            end else begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL run%0d: unexpected run of level 0x%02h for %0d clocks",
                             run_idx, cur_lvl, run_len);
                end else begin
                    e = exp_q.pop_front();
                    check($sformatf("run%0d", run_idx), cur_lvl, run_len, e);
                end
                run_idx++;
                cur_lvl = audio_out;
                run_len = 1;
            end
        end
    end

    initial begin
        rst_n  = 1'b0;
        butt_1 = 1'b1;
        butt_2 = 1'b0;
        butt_3 = 1'b0;
        butt_4 = 1'b0;
        oct    = 6'b000000;
        volsel = 2'b11;
        // 4 reset edges plus 2 synchronizer edges of silence, then A at N = 455.
        push(8'h00, 6);
        push(8'hFF, 455);
        push(8'h00, 455);
        push(8'hFF, 455);
        push(8'h00, 455);
        repeat (4) @(posedge clk);
        #1;
        rst_n   = 1'b1;
        edge_no = 0;

        // Octave 6 lands 100 samples into the high level starting at edge 1823.
        seen_at(1923);
        oct = 6'b100000;
        push(8'hFF, 107);
        for (int i = 0; i < 9; i++) push((i % 2 == 0) ? 8'h00 : 8'hFF, 7);

        // Same highest bit: no restart, period unchanged.
        seen_at(1941);
        oct = 6'b100001;

        seen_at(1993);
        volsel = 2'b00;
        push(8'h20, 7);
        push(8'h00, 7);

        // Lower priority button while A is held has no effect.
        seen_at(2001);
        butt_2 = 1'b1;

        // Volume change in the middle of a high level.
        seen_at(2010);
        volsel = 2'b01;
        push(8'h20, 3);
        push(8'h40, 4);
        push(8'h00, 7);

        seen_at(2021);
        volsel = 2'b10;
        push(8'h80, 7);
        push(8'h00, 7);

        seen_at(2035);
        volsel = 2'b11;
        push(8'hFF, 7);
        push(8'h00, 7);

        // Dropping A switches to C at edge 2053 with cnt restarted and phase kept.
        seen_at(2051);
        butt_1 = 1'b0;
        push(8'hFF, 9);
        push(8'h00, 5);
        push(8'hFF, 5);
        push(8'h00, 5);

        // Release everything: silence two edges later.
        seen_at(2073);
        butt_2 = 1'b0;
        push(8'hFF, 2);
        push(8'h00, 19);

        // A at octave 3 (N = 56) sounds at edge 2094.
        seen_at(2092);
        butt_1 = 1'b1;
        oct    = 6'b000100;
        push(8'hFF, 56);
        push(8'h00, 56);
        push(8'hFF, 15);

        // One-clock reset mid high level; tone returns with a full high level.
        seen_at(2221);
        rst_n = 1'b0;
        push(8'h00, 3);
        push(8'hFF, 56);
        push(8'h00, 56);
        seen_at(2222);
        rst_n = 1'b1;

        for (int i = 0; i < 1000 && exp_q.size() != 0; i++) @(posedge clk);
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d expected runs never observed, expected 0 outstanding",
                     exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
